line_fill_buffer: RTL and testbench

//  Downstream of the AXI read channel. Collects backend burst beats (read_valid/read_addr/read_rdata) into a full cache line.

---
 rtl/line_fill_buffer_if.sv | 51 +++++
 rtl/line_fill_buffer.sv | 133 +++++++++++++
 tb/tb_line_fill_buffer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_fill_buffer_if.sv
// rtl/line_fill_buffer_if.sv - read-channel beat inputs and line-write outputs of line_fill_buffer
// CACHE_FILL_STATS_EN adds the fill_cnt/retry_cnt statistics outputs.
interface line_fill_buffer_if #(
  parameter int FE_ADDR_W  = 32,
  parameter int FE_DATA_W  = 32,
  parameter int WORD_OFF_W = 3,
  parameter int BE_DATA_W  = 32
);
  localparam int BE_BYTE_W  = $clog2(BE_DATA_W / 8);
  localparam int LINE2MEM_W = WORD_OFF_W - $clog2(BE_DATA_W / FE_DATA_W);
  localparam int LINE_W     = FE_DATA_W * (2 ** WORD_OFF_W);
  localparam int LA_W       = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W;
  localparam int RA_W       = (LINE2MEM_W > 0) ? LINE2MEM_W : 1;

  logic                  replace;
  logic [LA_W-1:0]       fill_addr;
  logic [WORD_OFF_W-1:0] req_word;
  logic                  read_valid;
  logic [RA_W-1:0]       read_addr;
  logic [BE_DATA_W-1:0]  read_rdata;
  logic                  fill_busy;
  logic                  line_we;
  logic [LA_W-1:0]       line_addr;
  logic [LINE_W-1:0]     line_wdata;
  logic                  fwd_valid;
  logic [FE_DATA_W-1:0]  fwd_rdata;
`ifdef CACHE_FILL_STATS_EN
  logic [15:0]           fill_cnt;
  logic [15:0]           retry_cnt;

  modport master (
    output replace, fill_addr, req_word, read_valid, read_addr, read_rdata,
    input  fill_busy, line_we, line_addr, line_wdata, fwd_valid, fwd_rdata,
    input  fill_cnt, retry_cnt
  );
  modport slave (
    input  replace, fill_addr, req_word, read_valid, read_addr, read_rdata,
    output fill_busy, line_we, line_addr, line_wdata, fwd_valid, fwd_rdata,
    output fill_cnt, retry_cnt
  );
`else
  modport master (
    output replace, fill_addr, req_word, read_valid, read_addr, read_rdata,
    input  fill_busy, line_we, line_addr, line_wdata, fwd_valid, fwd_rdata
  );
  modport slave (
    input  replace, fill_addr, req_word, read_valid, read_addr, read_rdata,
    output fill_busy, line_we, line_addr, line_wdata, fwd_valid, fwd_rdata
  );
`endif
endinterface

// File: rtl/line_fill_buffer.sv
// rtl/line_fill_buffer.sv - assembles backend burst beats into a cache line and commits it once the refill is error-free
// CACHE_FILL_STATS_EN enables saturating fill/retry counters.
module line_fill_buffer #(
  parameter int FE_ADDR_W  = 32,
  parameter int FE_DATA_W  = 32,
  parameter int WORD_OFF_W = 3,
  parameter int BE_DATA_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  line_fill_buffer_if.slave  bus
);
  localparam int BE_BYTE_W  = $clog2(BE_DATA_W / 8);
  localparam int LINE2MEM_W = WORD_OFF_W - $clog2(BE_DATA_W / FE_DATA_W);
  localparam int LINE_W     = FE_DATA_W * (2 ** WORD_OFF_W);
  localparam int LA_W       = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W;
  localparam int RA_W       = (LINE2MEM_W > 0) ? LINE2MEM_W : 1;
  localparam int CNT_W      = LINE2MEM_W + 1;
  localparam int N_BEATS    = 2 ** LINE2MEM_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_END,
    S_SETTLE,
    S_COMMIT
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [LINE_W-1:0]     r_buf;
  logic [LA_W-1:0]       r_line_addr;
  logic [WORD_OFF_W-1:0] r_req_word;
  logic                  r_fill_busy;
  logic                  r_line_we;
  logic                  r_fwd_valid;
  logic [FE_DATA_W-1:0]  r_fwd_rdata;
`ifdef CACHE_FILL_STATS_EN
  logic [15:0]           r_fill_cnt;
  logic [15:0]           r_retry_cnt;
`endif

  // Single-beat lines have one slot, so read_addr carries no information there.
  logic [RA_W-1:0] w_slot;
  assign w_slot = (LINE2MEM_W == 0) ? '0 : bus.read_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_line_addr <= '0;
      r_req_word  <= '0;
      r_fill_busy <= 1'b0;
      r_line_we   <= 1'b0;
      r_fwd_valid <= 1'b0;
      r_fwd_rdata <= '0;
`ifdef CACHE_FILL_STATS_EN
      r_fill_cnt  <= '0;
      r_retry_cnt <= '0;
`endif
    end else begin
      r_line_we   <= 1'b0;
      r_fwd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.replace) begin
            r_line_addr <= bus.fill_addr;
            r_req_word  <= bus.req_word;
            r_cnt       <= '0;
            r_fill_busy <= 1'b1;
            r_state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (bus.read_valid) begin
            r_buf[int'(w_slot)*BE_DATA_W +: BE_DATA_W] <= bus.read_rdata;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_BEAT) begin
              r_state <= S_END;
            end
          end
        end
        S_END: begin
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          // replace still high here means the slave errored and the burst is re-issued.
          if (bus.replace) begin
            r_cnt   <= '0;
            r_state <= S_FILL;
`ifdef CACHE_FILL_STATS_EN
            if (r_retry_cnt != 16'hFFFF) begin
              r_retry_cnt <= r_retry_cnt + 16'd1;
            end
`endif
          end else begin
            r_line_we   <= 1'b1;
            r_fwd_valid <= 1'b1;
            r_fwd_rdata <= r_buf[int'(r_req_word)*FE_DATA_W +: FE_DATA_W];
            r_state     <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_fill_busy <= 1'b0;
          r_state     <= S_IDLE;
`ifdef CACHE_FILL_STATS_EN
          if (r_fill_cnt != 16'hFFFF) begin
            r_fill_cnt <= r_fill_cnt + 16'd1;
          end
`endif
        end
        default: begin
          r_fill_busy <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.fill_busy  = r_fill_busy;
  assign bus.line_we    = r_line_we;
  assign bus.line_addr  = r_line_addr;
  assign bus.line_wdata = r_buf;
  assign bus.fwd_valid  = r_fwd_valid;
  assign bus.fwd_rdata  = r_fwd_rdata;
`ifdef CACHE_FILL_STATS_EN
  assign bus.fill_cnt   = r_fill_cnt;
  assign bus.retry_cnt  = r_retry_cnt;
`endif

endmodule

// File: tb/tb_line_fill_buffer.sv
// tb/tb_line_fill_buffer.sv - scoreboard bench for line_fill_buffer (8-beat 32-bit and single-beat 256-bit builds)
// Stats checks compile in when CACHE_FILL_STATS_EN is defined.
module tb_line_fill_buffer;
  logic clk;
  logic rstn;
  int   cyc;
  int   checks;
  int   errors;
  int   busy_drops;

  typedef struct {
    logic [26:0]  addr;
    logic [255:0] data;
    logic [31:0]  fwd;
    int           cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  line_fill_buffer_if #(.FE_ADDR_W(32), .FE_DATA_W(32), .WORD_OFF_W(3), .BE_DATA_W(32))  if0 ();
  line_fill_buffer_if #(.FE_ADDR_W(32), .FE_DATA_W(32), .WORD_OFF_W(3), .BE_DATA_W(256)) if1 ();

  line_fill_buffer #(.FE_ADDR_W(32), .FE_DATA_W(32), .WORD_OFF_W(3), .BE_DATA_W(32)) u_dut (
    .clk   (clk),
    .reset (rstn),
    .bus   (if0)
  );

  line_fill_buffer #(.FE_ADDR_W(32), .FE_DATA_W(32), .WORD_OFF_W(3), .BE_DATA_W(256)) u_wide (
    .clk   (clk),
    .reset (rstn),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitors: every line_we must match the oldest expected commit.
  always @(negedge clk) begin
    if (rstn && if0.line_we) begin
      if (q0.size() == 0) begin
        check("dut0_unexpected_line_we", 256'd1, 256'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("dut0_line_addr", 256'(if0.line_addr), 256'(e.addr));
        check("dut0_line_wdata", if0.line_wdata, e.data);
        check("dut0_fwd_valid", 256'(if0.fwd_valid), 256'd1);
        check("dut0_fwd_rdata", 256'(if0.fwd_rdata), 256'(e.fwd));
        check("dut0_latency_cycle", 256'(cyc), 256'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && if1.line_we) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_line_we", 256'd1, 256'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("dut1_line_addr", 256'(if1.line_addr), 256'(e.addr));
        check("dut1_line_wdata", if1.line_wdata, e.data);
        check("dut1_fwd_valid", 256'(if1.fwd_valid), 256'd1);
        check("dut1_fwd_rdata", 256'(if1.fwd_rdata), 256'(e.fwd));
        check("dut1_latency_cycle", 256'(cyc), 256'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = base + 32'(i);
    return d;
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic start0(input logic [26:0] addr, input logic [2:0] req);
    if0.replace   = 1'b1;
    if0.fill_addr = addr;
    if0.req_word  = req;
    tick();
    tick();
  endtask

  task automatic burst0(input logic [31:0] base, input int nbeats, input bit gaps, output int c_last);
    c_last = 0;
    for (int i = 0; i < nbeats; i++) begin
      if0.read_valid = 1'b1;
      if0.read_addr  = 3'(i);
      if0.read_rdata = base + 32'(i);
      c_last = cyc;
      tick();
      if (!if0.fill_busy) busy_drops++;
      if (gaps && (i == 2 || i == 5)) begin
        if0.read_valid = 1'b0;
        if0.read_rdata = 32'hDEADBEEF;
        for (int g = 0; g < 2; g++) begin
          tick();
          if (!if0.fill_busy) busy_drops++;
        end
      end
    end
    if0.read_valid = 1'b0;
  endtask

  task automatic end_phase0(input bit retry);
    if0.replace = 1'b1;
    tick();
    if0.replace = retry;
    tick();
    if0.replace = 1'b0;
  endtask

  task automatic drain0();
    int n;
    n = 0;
    while (q0.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    check("dut0_drain", 256'(q0.size()), 256'd0);
  endtask

  task automatic push0(input logic [26:0] addr, input logic [31:0] base, input logic [31:0] fwd, input int c_last);
    exp_t e;
    e.addr = addr;
    e.data = mk_line(base);
    e.fwd  = fwd;
    e.cyc  = c_last + 3;
    q0.push_back(e);
  endtask

  initial begin
    int c_last;
    logic [255:0] pat;
    exp_t e;
    cyc = 0; checks = 0; errors = 0; busy_drops = 0;
    rstn = 1'b0;
    if0.replace = 1'b0; if0.fill_addr = '0; if0.req_word = '0;
    if0.read_valid = 1'b0; if0.read_addr = '0; if0.read_rdata = '0;
    if1.replace = 1'b0; if1.fill_addr = '0; if1.req_word = '0;
    if1.read_valid = 1'b0; if1.read_addr = '0; if1.read_rdata = '0;
    do_reset();

    check("reset_fill_busy", 256'(if0.fill_busy), 256'd0);
    check("reset_line_we", 256'(if0.line_we), 256'd0);
    check("reset_line_addr", 256'(if0.line_addr), 256'd0);
    check("reset_line_wdata", if0.line_wdata, 256'd0);
    check("reset_fwd", 256'({if0.fwd_valid, if0.fwd_rdata}), 256'd0);

    // Test 1: back-to-back beats
    start0(27'h00ABCDE, 3'd5);
    burst0(32'hA0, 8, 1'b0, c_last);
    push0(27'h00ABCDE, 32'hA0, 32'hA5, c_last);
    end_phase0(1'b0);
    drain0();
    check("t1_busy_after_commit", 256'(if0.fill_busy), 256'd0);

    // Test 2: gapped beats, busy must never drop
    busy_drops = 0;
    start0(27'h00ABCDE, 3'd5);
    burst0(32'hA0, 8, 1'b1, c_last);
    push0(27'h00ABCDE, 32'hA0, 32'hA5, c_last);
    end_phase0(1'b0);
    if (!if0.fill_busy) busy_drops++;
    drain0();
    check("t2_busy_drops", 256'(busy_drops), 256'd0);

    // Test 3: slave error retry
    do_reset();
    start0(27'h1555555, 3'd3);
    burst0(32'hB0, 8, 1'b0, c_last);
    end_phase0(1'b1);
    check("t3_busy_in_retry", 256'(if0.fill_busy), 256'd1);
    tick();
    burst0(32'hC0, 8, 1'b0, c_last);
    push0(27'h1555555, 32'hC0, 32'hC3, c_last);
    end_phase0(1'b0);
    drain0();
`ifdef CACHE_FILL_STATS_EN
    check("t3_fill_cnt", 256'(if0.fill_cnt), 256'd1);
    check("t3_retry_cnt", 256'(if0.retry_cnt), 256'd1);
`endif

    // Test 4: single 256-bit beat fills the whole line
    for (int b = 0; b < 32; b++) pat[b*8 +: 8] = 8'(b);
    if1.replace = 1'b1; if1.fill_addr = 27'h0000042; if1.req_word = 3'd7;
    tick();
    tick();
    if1.read_valid = 1'b1; if1.read_rdata = pat;
    e.addr = 27'h0000042; e.data = pat; e.fwd = 32'h1F1E1D1C; e.cyc = cyc + 3;
    q1.push_back(e);
    tick();
    if1.read_valid = 1'b0;
    tick();
    if1.replace = 1'b0;
    begin
      int n;
      n = 0;
      while (q1.size() != 0 && n < 20) begin
        tick();
        n++;
      end
    end
    tick();
    check("dut1_drain", 256'(q1.size()), 256'd0);

    // Test 5: reset mid-fill discards the partial line
    start0(27'h0000777, 3'd1);
    burst0(32'hE0, 3, 1'b0, c_last);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    if0.replace = 1'b0;
    check("t5_fill_busy", 256'(if0.fill_busy), 256'd0);
    check("t5_line_we", 256'(if0.line_we), 256'd0);
    check("t5_line_addr", 256'(if0.line_addr), 256'd0);
    check("t5_line_wdata", if0.line_wdata, 256'd0);
    check("t5_fwd", 256'({if0.fwd_valid, if0.fwd_rdata}), 256'd0);
    tick();
    start0(27'h1234567, 3'd2);
    burst0(32'hD0, 8, 1'b0, c_last);
    push0(27'h1234567, 32'hD0, 32'hD2, c_last);
    end_phase0(1'b0);
    drain0();

    // Test 6: read_valid while idle is ignored
    for (int i = 0; i < 3; i++) begin
      if0.read_valid = 1'b1;
      if0.read_addr  = 3'(i);
      if0.read_rdata = 32'h5A5A0000 + 32'(i);
      tick();
      if (if0.fill_busy) busy_drops++;
    end
    if0.read_valid = 1'b0;
    tick();
    tick();
    check("t6_fill_busy", 256'(if0.fill_busy), 256'd0);
    check("t6_line_wdata_kept", if0.line_wdata, mk_line(32'hD0));
    check("t6_line_addr_kept", 256'(if0.line_addr), 256'h1234567);
`ifdef CACHE_FILL_STATS_EN
    check("t6_fill_cnt", 256'(if0.fill_cnt), 256'd1);
    check("t6_retry_cnt", 256'(if0.retry_cnt), 256'd0);
`endif
    check("final_q0_empty", 256'(q0.size()), 256'd0);
    check("final_q1_empty", 256'(q1.size()), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
